// File: rtl/mil_ring_pkg.sv
// mil_ring_pkg: shared types and helpers for the MIL ring-buffer writer.
//   state_e  - writer FSM states
//   WORD_W   - stream / memory word width
//   ofs_inc  - wrapping increment of a ring offset in [0, size)
package mil_ring_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    COMMIT,
    DROP,
    DISCARD
  } state_e;

  // Next offset in a ring of 'size' entries, wrapping to 0 after size-1.
  function automatic int unsigned ofs_inc(input int unsigned ofs, input int unsigned size);
    return (ofs + 32'd1 >= size) ? 32'd0 : ofs + 32'd1;
  endfunction

endpackage

// File: rtl/ring_offset_ctr.sv
// ring_offset_ctr: loadable wrapping offset counter for a ring of SIZE words.
// Ports:
//   clk, nRst  - clock, asynchronous active-low reset (value -> 0)
//   inc        - advance by one, wrapping at SIZE
//   load       - load load_val (wins over inc)
//   load_val   - value to load
//   value      - current offset
module ring_offset_ctr
  import mil_ring_pkg::*;
#(
  parameter int unsigned SIZE = 256,
  parameter int unsigned OW   = 8
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          inc,
  input  logic          load,
  input  logic [OW-1:0] load_val,
  output logic [OW-1:0] value
);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= OW'(ofs_inc(32'(value), SIZE));
    end
  end

endmodule

// File: rtl/mil_ring_writer.sv
// mil_ring_writer: packet-framed ring-buffer producer. Turns a word stream into
// single-word memory write requests in the ring [BASE, BASE+SIZE), publishes
// only whole packets and rolls back packets that overflow the free space.
// Ports:
//   clk, nRst                      - clock, asynchronous active-low reset
//   in_data/in_valid/in_last       - input stream, in_ready accepts a word
//   wr_request/wr_addr/wr_data     - write request to the memory writer
//   wr_done                        - one-cycle write completion
//   rd_release                     - consumer frees one committed word
//   commit_ptr                     - address one past the last committed word
//   used_words                     - committed, unreleased words
//   pkt_commit / pkt_drop          - one-cycle packet outcome pulses
// Optional (RING_STATS_EN defined):
//   drop_count - saturating count of dropped packets
//   wr_words   - wrapping count of completed writes
module mil_ring_writer
  import mil_ring_pkg::*;
#(
  parameter int unsigned       ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int unsigned       SIZE   = 256
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       wr_request,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [WORD_W-1:0]          wr_data,
  input  logic                       wr_done,
  input  logic                       rd_release,
  output logic [ADDR_W-1:0]          commit_ptr,
  output logic [$clog2(SIZE+1)-1:0]  used_words,
  output logic                       pkt_commit,
  output logic                       pkt_drop
`ifdef RING_STATS_EN
  ,
  output logic [15:0]                drop_count,
  output logic [15:0]                wr_words
`endif
);

  localparam int unsigned OW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned UW = $clog2(SIZE + 1);

  state_e          state_q, state_d;
  logic [OW-1:0]   wr_ofs, commit_ofs;
  logic [UW-1:0]   pkt_len_q;
  logic            last_q;
  logic            full_c;
  logic            done_c;
  logic            rel_c;

  // Ring is full when committed plus in-flight words cover every slot.
  assign full_c = (32'(used_words) + 32'(pkt_len_q)) >= SIZE;
  assign done_c = (state_q == WRITE) && wr_done;
  assign rel_c  = rd_release && (used_words != '0);

  assign pkt_commit = (state_q == COMMIT);
  assign pkt_drop   = (state_q == DROP);
  assign commit_ptr = BASE + ADDR_W'(commit_ofs);

  // Write offset: advances per completed write, rolls back to commit on drop.
  ring_offset_ctr #(.SIZE(SIZE), .OW(OW)) u_wr_ofs (
    .clk      (clk),
    .nRst     (nRst),
    .inc      (done_c),
    .load     (state_q == DROP),
    .load_val (commit_ofs),
    .value    (wr_ofs)
  );

  // Commit offset: snaps to the write offset when a packet completes.
  ring_offset_ctr #(.SIZE(SIZE), .OW(OW)) u_commit_ofs (
    .clk      (clk),
    .nRst     (nRst),
    .inc      (1'b0),
    .load     (state_q == COMMIT),
    .load_val (wr_ofs),
    .value    (commit_ofs)
  );

  // State register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; in_ready and wr_request are combinational handshake terms.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    wr_request = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !full_c;
        if (in_valid) state_d = full_c ? DROP : WRITE;
      end
      WRITE: begin
        // Low in the done cycle so the writer never sees a second request.
        wr_request = !wr_done;
        if (wr_done) state_d = last_q ? COMMIT : IDLE;
      end
      COMMIT:  state_d = IDLE;
      DROP:    state_d = last_q ? IDLE : DISCARD;
      DISCARD: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request payload, packet tracking and committed occupancy.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_addr    <= BASE;
      wr_data    <= '0;
      last_q     <= 1'b0;
      pkt_len_q  <= '0;
      used_words <= '0;
    end else begin
      if (state_q == IDLE && in_valid && in_ready) begin
        wr_addr <= BASE + ADDR_W'(wr_ofs);
        wr_data <= in_data;
        last_q  <= in_last;
      end
      // last_q marks "current packet has accepted its last word"; clear per packet.
      if (state_q == COMMIT || state_q == DROP) begin
        last_q    <= 1'b0;
        pkt_len_q <= '0;
      end else if (done_c) begin
        pkt_len_q <= pkt_len_q + UW'(1);
      end
      if (state_q == COMMIT) begin
        used_words <= used_words + pkt_len_q - UW'(rel_c);
      end else if (rel_c) begin
        used_words <= used_words - UW'(1);
      end
    end
  end

`ifdef RING_STATS_EN
  // Drop counter saturates; write counter wraps.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      drop_count <= '0;
      wr_words   <= '0;
    end else begin
      if (state_q == DROP && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (done_c) wr_words <= wr_words + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mil_ring_writer.sv
// tb_mil_ring_writer: directed self-checking bench for mil_ring_writer with
// BASE=16'h0100, SIZE=8 and a memory writer model that acks 4 cycles after request.
module tb_mil_ring_writer;

  localparam int unsigned ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'h0100;
  localparam int unsigned SIZE   = 8;
  localparam int unsigned UW     = $clog2(SIZE + 1);

  logic              clk;
  logic              nRst;
  logic [15:0]       in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              wr_request;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_done;
  logic              rd_release;
  logic [ADDR_W-1:0] commit_ptr;
  logic [UW-1:0]     used_words;
  logic              pkt_commit;
  logic              pkt_drop;
`ifdef RING_STATS_EN
  logic [15:0]       drop_count;
  logic [15:0]       wr_words;
`endif

  mil_ring_writer #(.ADDR_W(ADDR_W), .BASE(BASE), .SIZE(SIZE)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .wr_request (wr_request),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .rd_release (rd_release),
    .commit_ptr (commit_ptr),
    .used_words (used_words),
    .pkt_commit (pkt_commit),
    .pkt_drop   (pkt_drop)
`ifdef RING_STATS_EN
    ,
    .drop_count (drop_count),
    .wr_words   (wr_words)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int commits = 0;
  int drops = 0;
  int wcnt = 0;
  int ack_dly = 4;
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];

  // Memory writer model: completes each request ack_dly cycles after it rises.
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_done <= 1'b0;
      wcnt    <= 0;
    end else begin
      wr_done <= 1'b0;
      if (wr_request && !wr_done) begin
        if (wcnt == ack_dly - 1) begin
          wr_done <= 1'b1;
          wcnt    <= 0;
          log_addr.push_back(wr_addr);
          log_data.push_back(wr_data);
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  always @(posedge clk) begin
    if (pkt_commit === 1'b1) commits++;
    if (pkt_drop === 1'b1) drops++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_data    = '0;
    rd_release = 1'b0;
    nRst       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer one word and return #1 after the edge that accepts it.
  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_wait_expired", 32'(n >= 200), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] d0, input int n);
    for (int i = 0; i < n; i++) send(d0 + 16'(i), i == n - 1);
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic release_n(input int n);
    rd_release = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rd_release = 1'b0;
  endtask

  int i0, c0, d0, n;

  initial begin
    // Reset state
    do_reset();
    check("rst_commit_ptr", 32'(commit_ptr), 32'h0100);
    check("rst_used", 32'(used_words), 32'd0);
    check("rst_wr_request", 32'(wr_request), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0100);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 3-word packet A1..A3
    i0 = log_addr.size();
    c0 = commits;
    send(16'hA001, 1'b0);
    check("t1_req_latency", 32'(wr_request), 32'd1);
    check("t1_req_addr", 32'(wr_addr), 32'h0100);
    check("t1_req_data", 32'(wr_data), 32'hA001);
    send(16'hA002, 1'b0);
    send(16'hA003, 1'b1);
    settle();
    check("t1_nwrites", 32'(log_addr.size() - i0), 32'd3);
    check("t1_addr0", 32'(log_addr[i0]), 32'h0100);
    check("t1_addr1", 32'(log_addr[i0+1]), 32'h0101);
    check("t1_addr2", 32'(log_addr[i0+2]), 32'h0102);
    check("t1_data2", 32'(log_data[i0+2]), 32'hA003);
    check("t1_commits", 32'(commits - c0), 32'd1);
    check("t1_commit_ptr", 32'(commit_ptr), 32'h0103);
    check("t1_used", 32'(used_words), 32'd3);

    // Wrap: 6 committed, release 6, then 4-word packet
    do_reset();
    send_pkt(16'hB000, 6);
    settle();
    check("t2_used6", 32'(used_words), 32'd6);
    check("t2_ptr6", 32'(commit_ptr), 32'h0106);
    release_n(6);
    check("t2_used0", 32'(used_words), 32'd0);
    i0 = log_addr.size();
    send_pkt(16'hB100, 4);
    settle();
    check("t2_nwrites", 32'(log_addr.size() - i0), 32'd4);
    check("t2_addr0", 32'(log_addr[i0]), 32'h0106);
    check("t2_addr1", 32'(log_addr[i0+1]), 32'h0107);
    check("t2_addr2", 32'(log_addr[i0+2]), 32'h0100);
    check("t2_addr3", 32'(log_addr[i0+3]), 32'h0101);
    check("t2_used4", 32'(used_words), 32'd4);
    check("t2_commit_ptr", 32'(commit_ptr), 32'h0102);

    // Overflow: used=6, 4-word packet dropped after 2 writes
    do_reset();
    send_pkt(16'hC000, 6);
    settle();
    i0 = log_addr.size();
    c0 = commits;
    d0 = drops;
    send_pkt(16'hC100, 4);
    settle();
    check("t3_nwrites", 32'(log_addr.size() - i0), 32'd2);
    check("t3_addr0", 32'(log_addr[i0]), 32'h0106);
    check("t3_addr1", 32'(log_addr[i0+1]), 32'h0107);
    check("t3_drops", 32'(drops - d0), 32'd1);
    check("t3_commits", 32'(commits - c0), 32'd0);
    check("t3_commit_ptr", 32'(commit_ptr), 32'h0106);
    check("t3_used", 32'(used_words), 32'd6);
    send(16'hD000, 1'b1);
    settle();
    check("t3_restart_addr", 32'(log_addr[i0+2]), 32'h0106);
    check("t3_restart_data", 32'(log_data[i0+2]), 32'hD000);
    check("t3_restart_used", 32'(used_words), 32'd7);
    check("t3_restart_ptr", 32'(commit_ptr), 32'h0107);

    // Release during COMMIT of a 2-word packet with used=5
    do_reset();
    send_pkt(16'hE000, 5);
    settle();
    check("t4_used5", 32'(used_words), 32'd5);
    send(16'hE100, 1'b0);
    send(16'hE101, 1'b1);
    n = 0;
    @(negedge clk);
    while (pkt_commit !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_commit_seen", 32'(pkt_commit), 32'd1);
    rd_release = 1'b1;
    @(posedge clk);
    #1;
    rd_release = 1'b0;
    check("t4_used_net", 32'(used_words), 32'd6);
    release_n(6);
    check("t4_used_drained", 32'(used_words), 32'd0);
    release_n(1);
    check("t4_release_at0", 32'(used_words), 32'd0);

    // Reset in the middle of a write
    do_reset();
    send(16'hF000, 1'b0);
    check("t5_req_before", 32'(wr_request), 32'd1);
    @(posedge clk);
    #2;
    nRst = 1'b0;
    #1;
    check("t5_req_async", 32'(wr_request), 32'd0);
    check("t5_commit_ptr", 32'(commit_ptr), 32'h0100);
    check("t5_wr_addr", 32'(wr_addr), 32'h0100);
    check("t5_used", 32'(used_words), 32'd0);
    c0 = commits;
    @(negedge clk);
    nRst = 1'b1;
    settle();
    check("t5_no_commit", 32'(commits - c0), 32'd0);
    check("t5_req_idle", 32'(wr_request), 32'd0);

    // Full ring, then three overflowed packets
    do_reset();
    send_pkt(16'h1000, 8);
    settle();
    check("t6_used_full", 32'(used_words), 32'd8);
    check("t6_ptr_wrap", 32'(commit_ptr), 32'h0100);
    d0 = drops;
    for (int k = 0; k < 3; k++) send(16'h2000 + 16'(k), 1'b1);
    settle();
    check("t6_drops", 32'(drops - d0), 32'd3);
    check("t6_used_kept", 32'(used_words), 32'd8);
`ifdef RING_STATS_EN
    check("t6_drop_count", 32'(drop_count), 32'd3);
    check("t6_wr_words", 32'(wr_words), 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mil_ring_writer.md
Name: mil_ring_writer

Overview:
- Packet-framed ring-buffer producer that turns a word stream from the MIL/SPI receive path into single-word write requests for the memory writer stage, via its request/addr/data/done handshake.
- Maintains a circular region [BASE, BASE+SIZE) in shared memory.
- Exposes only whole committed packets to the consumer; drops any packet that overflows the free space and rolls back to the last committed pointer.

Parameters:
- ADDR_W, 16, memory address width
- BASE, 0, first word address of the ring region
- SIZE, 256, ring length in words, >=2

Ports:
- clk  in  1  clock
- nRst  in  1  asynchronous active-low reset
- in_data  in  16  stream word
- in_valid  in  1  word available
- in_last  in  1  word ends a packet
- in_ready  out  1  word accepted when in_valid&in_ready
- wr_request  out  1  write request to memory writer
- wr_addr  out  ADDR_W  write address, held while request high
- wr_data  out  16  write data, held while request high
- wr_done  in  1  one-cycle write completion from memory writer
- rd_release  in  1  consumer frees one word (pulse)
- commit_ptr  out  ADDR_W  address one past the last committed word
- used_words  out  clog2(SIZE+1)  committed, unreleased words
- pkt_commit  out  1  one-cycle pulse per committed packet
- pkt_drop  out  1  one-cycle pulse per dropped packet

Behaviour:
- Reset (async, nRst low): state IDLE; write and commit offsets 0; pkt_len 0; used_words 0; all pulses 0; wr_request 0; commit_ptr=BASE; wr_addr=BASE; wr_data 0. wr_request falls immediately, mid-write included.
- Offsets run 0..SIZE-1 and wrap to 0. Address = BASE + offset.
- free = SIZE - used_words - pkt_len; full = (free==0).
- IDLE
  - in_ready = !full.
  - On accept: latch data, latch last flag, wr_addr = BASE + wr_ofs, go to WRITE.
  - in_valid while full: go to DROP, no accept.
- WRITE
  - wr_request = !wr_done (combinational), so request is already low in the done cycle and the writer cannot re-issue.
  - On wr_done: wr_ofs+1 (wrap), pkt_len+1; go to COMMIT if the last flag is set, else IDLE.
  - in_ready = 0.
- COMMIT (1 cycle)
  - commit_ofs <= wr_ofs; used_words += pkt_len; pkt_len <= 0; pkt_commit=1; go to IDLE.
- DROP (1 cycle)
  - wr_ofs <= commit_ofs; pkt_len <= 0; pkt_drop=1.
  - If the dropped packet had already accepted its in_last word, go to IDLE; else go to DISCARD.
- DISCARD
  - in_ready = 1; consume words with no writes; on accepted in_last, go to IDLE.
- Packet longer than free space: the first word that finds full triggers DROP; partially written words are abandoned and never committed.
- rd_release
  - Decrements used_words by 1 in any state if used_words>0; ignored at 0.
  - In the same cycle as COMMIT, the net change is pkt_len-1.
- Latency: accept to wr_request is 1 cycle; done to next in_ready is 1 cycle (2 for last words via COMMIT).
- used_words never exceeds SIZE.

Optional Feature:
- RING_STATS_EN defined:
  - Adds output drop_count[15:0], reset 0.
  - Increments on each pkt_drop and saturates at 16'hFFFF.
  - Also adds output wr_words[15:0], a wrapping count of completed wr_done.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package mil_ring_pkg holds:
  - state enum {IDLE, WRITE, COMMIT, DROP, DISCARD}
  - WORD_W=16
  - function ofs_inc(ofs, size) for wrap increment
- One natural sub-module, ring_offset_ctr: loadable wrapping counter with inc, load and value, instanced for the write and commit offsets.

Test Plan (BASE=16'h0100, SIZE=8):
- 3-word packet A1,A2,A3(last), writer acks 4 cycles after request -> writes to 0x0100..0x0102 in order; one pkt_commit; commit_ptr=0x0103; used_words=3.
- Fill with 6 committed words, release 6, then 4-word packet -> addresses 0x0106,0x0107,0x0100,0x0101 (wrap); used_words=4.
- used_words=6, 4-word packet -> 2 writes, third word sees full -> pkt_drop, words 3-4 consumed with no request; commit_ptr unchanged; next packet starts at the old commit address.
- rd_release in the COMMIT cycle of a 2-word packet with used_words=5 -> used_words=6; rd_release with used_words=0 -> stays 0.
- nRst low while wr_request=1 -> wr_request 0 in the same cycle, pointers at BASE, no pkt_commit after release of reset.
- RING_STATS_EN: three overflowed packets -> drop_count=3.
